vga_timing_gen: RTL and testbench

//  Source end of the DrawX/DrawY/blank pixel interface consumed by every sprite/background renderer.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/vga_axis_counter.sv | 34 +++
 rtl/vga_timing_gen.sv | 103 ++++++++++
 tb/tb_vga_timing_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and the coordinate type for the VGA timing generator.
// The defaults describe 640x480 at 60 Hz.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..WRAP while enabled and pulses wrap on the WRAP->0 step.
// value_next is exported so the parent can register outputs aligned with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter coord_t WRAP = coord_t'(H_TOTAL - 1)
) (
    input  logic   vga_clk,
    input  logic   reset,
    input  logic   enable,
    output coord_t value,
    output coord_t value_next,
    output logic   wrap
);

    assign wrap = enable && (value == WRAP);

    always_comb begin
        value_next = value;
        if (enable) begin
            value_next = wrap ? '0 : value + coord_t'(1);
        end
    end

    // Resetting to WRAP makes the first enabled edge land on coordinate 0.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            value <= WRAP;
        end else begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source: sync, drawable flag, pixel coordinate and start pulses.
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
    import vga_timing_pkg::coord_t;
#(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
    localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t h_value;
    coord_t h_next;
    logic   h_wrap;
    coord_t v_value;
    coord_t v_next;
    logic   v_wrap;

    vga_axis_counter #(
        .WRAP(coord_t'(H_TOTAL - 1))
    ) u_h_counter (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .enable    (1'b1),
        .value     (h_value),
        .value_next(h_next),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .WRAP(coord_t'(V_TOTAL - 1))
    ) u_v_counter (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .enable    (h_wrap),
        .value     (v_value),
        .value_next(v_next),
        .wrap      (v_wrap)
    );

    assign DrawX = h_value;
    assign DrawY = v_value;

    // Decoding the next counts keeps every flag in the same cycle as the coordinate it describes.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs          <= (h_next >= HS_START && h_next < HS_END) ? SYNC_POL : ~SYNC_POL;
            vs          <= (v_next >= VS_START && v_next < VS_END) ? SYNC_POL : ~SYNC_POL;
            blank       <= (h_next < H_VIS_END) && (v_next < V_VIS_END);
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (h_next == '0 && v_next == '0) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line timing and async reset, and a
// reduced-geometry active-high-sync instance for whole-frame timing.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic        rst_a, rst_b;
    logic        hs_a, vs_a, blank_a, ls_a, fs_a;
    logic [9:0]  x_a, y_a;
    logic        hs_b, vs_b, blank_b, ls_b, fs_b;
    logic [9:0]  x_b, y_b;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    int errors = 0;
    int checks = 0;

    vga_timing_gen dut (
        .vga_clk    (vga_clk),
        .reset      (rst_a),
        .hs         (hs_a),
        .vs         (vs_a),
        .blank      (blank_a),
        .DrawX      (x_a),
        .DrawY      (y_a),
        .line_start (ls_a),
        .frame_start(fs_a)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count(fc_a)
`endif
    );

    // 16x9 raster: visible 8x4, hs 10..12, vs lines 5..6, syncs asserted high.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL (1'b1)
    ) dut_s (
        .vga_clk    (vga_clk),
        .reset      (rst_b),
        .hs         (hs_b),
        .vs         (vs_b),
        .blank      (blank_b),
        .DrawX      (x_b),
        .DrawY      (y_b),
        .line_start (ls_b),
        .frame_start(fs_b)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count(fc_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int ex, ey, hs_low, ls_cnt, fs_cnt, last_fs, k;

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge vga_clk);
        check("rst_a DrawX", x_a, 799);
        check("rst_a DrawY", y_a, 524);
        check("rst_a hs", hs_a, 1);
        check("rst_a vs", vs_a, 1);
        check("rst_a blank", blank_a, 0);
        check("rst_a line_start", ls_a, 0);
        check("rst_a frame_start", fs_a, 0);
        check("rst_b DrawX", x_b, 15);
        check("rst_b DrawY", y_b, 8);
        check("rst_b hs", hs_b, 0);
        check("rst_b vs", vs_b, 0);
`ifdef VGA_FRAME_COUNT_EN
        check("rst_a frame_count", fc_a, 0);
`endif
        $display("phase reset: checks=%0d errors=%0d", checks, errors);

        // Default geometry: two full lines plus the start of a third.
        rst_a  = 1'b0;
        hs_low = 0;
        ls_cnt = 0;
        fs_cnt = 0;
        for (int i = 0; i < 1700; i++) begin
            @(negedge vga_clk);
            ex = i % 800;
            ey = i / 800;
            if (i == 0) begin
                check("first blank", blank_a, 1);
                check("first line_start", ls_a, 1);
                check("first frame_start", fs_a, 1);
            end
            if (ex inside {0, 1, 639, 640, 655, 656, 751, 752, 799}) begin
                check($sformatf("line DrawX@%0d", i), x_a, ex);
                check($sformatf("line DrawY@%0d", i), y_a, ey);
                check($sformatf("line hs@x%0d", ex), hs_a, (ex >= 656 && ex < 752) ? 0 : 1);
                check($sformatf("line blank@x%0d", ex), blank_a, (ex < 640) ? 1 : 0);
                check($sformatf("line vs@x%0d", ex), vs_a, 1);
            end
            if (!hs_a) hs_low++;
            if (ls_a) ls_cnt++;
            if (fs_a) fs_cnt++;
        end
        check("hs low cycles", hs_low, 192);
        check("line_start count", ls_cnt, 3);
        check("frame_start count", fs_cnt, 1);
`ifdef VGA_FRAME_COUNT_EN
        check("frame_count a", fc_a, 1);
`endif
        $display("phase line: checks=%0d errors=%0d", checks, errors);

        // Async reset while inside horizontal sync.
        k = 0;
        while (x_a != 10'd700 && k < 1000) begin
            @(negedge vga_clk);
            k++;
        end
        check("reach DrawX 700", x_a, 700);
        check("hs at 700", hs_a, 0);
        rst_a = 1'b1;
        #1;
        check("async DrawX", x_a, 799);
        check("async DrawY", y_a, 524);
        check("async hs", hs_a, 1);
        check("async blank", blank_a, 0);
        $display("phase async reset a: checks=%0d errors=%0d", checks, errors);

        // Reduced geometry: three full frames checked every cycle.
        @(negedge vga_clk);
        rst_b   = 1'b0;
        fs_cnt  = 0;
        last_fs = -1;
        for (int i = 0; i < 432; i++) begin
            @(negedge vga_clk);
            ex = i % 16;
            ey = (i / 16) % 9;
            check("s DrawX", x_b, ex);
            check("s DrawY", y_b, ey);
            check("s hs", hs_b, (ex >= 10 && ex < 13) ? 1 : 0);
            check("s vs", vs_b, (ey >= 5 && ey < 7) ? 1 : 0);
            check("s blank", blank_b, (ex < 8 && ey < 4) ? 1 : 0);
            check("s line_start", ls_b, (ex == 0) ? 1 : 0);
            check("s frame_start", fs_b, (ex == 0 && ey == 0) ? 1 : 0);
`ifdef VGA_FRAME_COUNT_EN
            check("s frame_count", fc_b, i / 144 + 1);
`endif
            if (fs_b) begin
                if (last_fs >= 0) check("frame period", i - last_fs, 144);
                last_fs = i;
                fs_cnt++;
            end
        end
        check("s frame_start count", fs_cnt, 3);
`ifdef VGA_FRAME_COUNT_EN
        check("s frame_count after 3", fc_b, 3);
`endif
        $display("phase frame: checks=%0d errors=%0d", checks, errors);

        // Async reset while both syncs are asserted.
        k = 0;
        while (!(y_b == 10'd5 && x_b == 10'd11) && k < 300) begin
            @(negedge vga_clk);
            k++;
        end
        check("s reach sync", {y_b, x_b}, {10'd5, 10'd11});
        check("s hs in sync", hs_b, 1);
        check("s vs in sync", vs_b, 1);
        rst_b = 1'b1;
        #1;
        check("s async DrawX", x_b, 15);
        check("s async DrawY", y_b, 8);
        check("s async hs", hs_b, 0);
        check("s async vs", vs_b, 0);
        check("s async blank", blank_b, 0);
        $display("phase async reset b: checks=%0d errors=%0d", checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
